// File: rtl/fp_pkg.sv
// Shared constants, operand layout and unpack helper for the FP add/sub pipeline.
package fp_pkg;

  localparam int unsigned FP_LATENCY = 7;
  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned EXP_W      = 8;
  localparam int unsigned FRAC_W     = 23;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  // Unpack a binary32 value, optionally flipping its sign; denormals flush to signed zero.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x, input logic flip);
    fp_unpacked_t     u;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e         = x[30:23];
    f         = x[22:0];
    u.sign    = x[31] ^ flip;
    u.exp     = e;
    u.mant    = {1'b1, f};
    u.is_zero = (e == '0);
    u.is_inf  = (e == '1) && (f == '0);
    u.is_nan  = (e == '1) && (f != '0);
    if (u.is_zero) begin
      u.exp  = '0;
      u.mant = '0;
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational 27-bit leading-zero counter; all-zero input reports 27.
module fp_lzc (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    count = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// Pipelined binary32 adder/subtractor: unpack, swap, align, add, LZC, normalize, round, pack.
module fp_add_sub
  import fp_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        add_sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  // Special-case outcome and sign travel alongside the datapath.
  typedef struct packed {
    logic        special;
    logic [31:0] spec;
    logic        sign;
  } ctl_t;

  fp_unpacked_t       s1_a, s1_b;
  ctl_t               st2_ctl, s2_ctl, s3_ctl, s4_ctl, s5_ctl, s6_ctl, s7_ctl;
  logic               a_ge_b;
  logic signed [9:0]  s2_exp, s3_exp, s4_exp, s5_exp, s6_exp, s7_exp;
  logic [23:0]        s2_mbig, s2_msmall;
  logic [7:0]         s2_diff;
  logic               s2_sub, s3_sub;
  logic [4:0]         st3_sh;
  logic [26:0]        st3_ext, st3_mask, st3_shifted;
  logic               st3_sticky;
  logic [26:0]        s3_mbig, s3_msmall;
  logic [27:0]        s4_sum, s5_sum;
  logic [4:0]         st5_lz, s5_lz;
  logic               s5_zero, s6_zero, s7_zero;
  logic [26:0]        st6_m, s6_m;
  logic signed [9:0]  st6_e, st7_e;
  logic               st7_up;
  logic [24:0]        st7_mr;
  logic [22:0]        st7_frac, s7_frac;
  logic [31:0]        st8_res;

  // Stage 1: unpack and classify; subtraction folds into datab's sign.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      s1_a <= fp_unpack(dataa, 1'b0);
      s1_b <= fp_unpack(datab, add_sub);
    end
  end

  // Special-case priority and magnitude comparison for the swap.
  always_comb begin
    st2_ctl.special = 1'b1;
    st2_ctl.spec    = '0;
    if (s1_a.is_nan || s1_b.is_nan)                              st2_ctl.spec = QNAN;
    else if (s1_a.is_inf && s1_b.is_inf && (s1_a.sign != s1_b.sign)) st2_ctl.spec = QNAN;
    else if (s1_a.is_inf)                                        st2_ctl.spec = POS_INF | {s1_a.sign, 31'b0};
    else if (s1_b.is_inf)                                        st2_ctl.spec = POS_INF | {s1_b.sign, 31'b0};
    else if (s1_a.is_zero && s1_b.is_zero)                       st2_ctl.spec = {s1_a.sign & s1_b.sign, 31'b0};
    else if (s1_a.is_zero)                                       st2_ctl.spec = {s1_b.sign, s1_b.exp, s1_b.mant[22:0]};
    else if (s1_b.is_zero)                                       st2_ctl.spec = {s1_a.sign, s1_a.exp, s1_a.mant[22:0]};
    else                                                         st2_ctl.special = 1'b0;
    a_ge_b       = {s1_a.exp, s1_a.mant} >= {s1_b.exp, s1_b.mant};
    st2_ctl.sign = a_ge_b ? s1_a.sign : s1_b.sign;
  end

  // Stage 2: larger magnitude first, exponent difference.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s2_ctl <= '0; s2_exp <= '0; s2_mbig <= '0; s2_msmall <= '0; s2_diff <= '0; s2_sub <= 1'b0;
    end else begin
      s2_ctl    <= st2_ctl;
      s2_exp    <= {2'b00, (a_ge_b ? s1_a.exp : s1_b.exp)};
      s2_mbig   <= a_ge_b ? s1_a.mant : s1_b.mant;
      s2_msmall <= a_ge_b ? s1_b.mant : s1_a.mant;
      s2_diff   <= a_ge_b ? (s1_a.exp - s1_b.exp) : (s1_b.exp - s1_a.exp);
      s2_sub    <= s1_a.sign ^ s1_b.sign;
    end
  end

  // Saturating right shift of the smaller significand with sticky collection.
  always_comb begin
    st3_sh      = (s2_diff > 8'd26) ? 5'd26 : s2_diff[4:0];
    st3_ext     = {s2_msmall, 3'b000};
    st3_mask    = '1;
    st3_mask    = ~(st3_mask << st3_sh);
    st3_shifted = st3_ext >> st3_sh;
    st3_sticky  = |(st3_ext & st3_mask);
  end

  // Stage 3: aligned significands with guard/round/sticky.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s3_ctl <= '0; s3_exp <= '0; s3_mbig <= '0; s3_msmall <= '0; s3_sub <= 1'b0;
    end else begin
      s3_ctl    <= s2_ctl;
      s3_exp    <= s2_exp;
      s3_mbig   <= {s2_mbig, 3'b000};
      s3_msmall <= {st3_shifted[26:1], st3_shifted[0] | st3_sticky};
      s3_sub    <= s2_sub;
    end
  end

  // Stage 4: magnitude add or subtract; the swap keeps subtraction non-negative.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s4_ctl <= '0; s4_exp <= '0; s4_sum <= '0;
    end else begin
      s4_ctl <= s3_ctl;
      s4_exp <= s3_exp;
      s4_sum <= s3_sub ? ({1'b0, s3_mbig} - {1'b0, s3_msmall})
                       : ({1'b0, s3_mbig} + {1'b0, s3_msmall});
    end
  end

  fp_lzc u_lzc (
    .value (s4_sum[26:0]),
    .count (st5_lz)
  );

  // Stage 5: leading-zero count feeding the normalizer; a zero sum is exact cancellation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s5_ctl <= '0; s5_exp <= '0; s5_sum <= '0; s5_lz <= '0; s5_zero <= 1'b0;
    end else begin
      s5_ctl  <= s4_ctl;
      s5_exp  <= s4_exp;
      s5_sum  <= s4_sum;
      s5_lz   <= st5_lz;
      s5_zero <= (s4_sum == '0);
    end
  end

  // Carry-out shifts right one (keeping sticky); otherwise shift left by the zero count.
  always_comb begin
    if (s5_sum[27]) begin
      st6_m = {s5_sum[27:2], s5_sum[1] | s5_sum[0]};
      st6_e = s5_exp + 10'sd1;
    end else begin
      st6_m = s5_sum[26:0] << s5_lz;
      st6_e = s5_exp - $signed({5'b00000, s5_lz});
    end
  end

  // Stage 6: normalized significand.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s6_ctl <= '0; s6_exp <= '0; s6_m <= '0; s6_zero <= 1'b0;
    end else begin
      s6_ctl  <= s5_ctl;
      s6_exp  <= st6_e;
      s6_m    <= st6_m;
      s6_zero <= s5_zero;
    end
  end

  // Round to nearest even, renormalizing when the increment carries out.
  always_comb begin
    st7_up = s6_m[2] & (s6_m[1] | s6_m[0] | s6_m[3]);
    st7_mr = {1'b0, s6_m[26:3]} + {24'b0, st7_up};
    if (st7_mr[24]) begin
      st7_frac = st7_mr[23:1];
      st7_e    = s6_exp + 10'sd1;
    end else begin
      st7_frac = st7_mr[22:0];
      st7_e    = s6_exp;
    end
  end

  // Stage 7: rounded fraction and final exponent.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s7_ctl <= '0; s7_exp <= '0; s7_frac <= '0; s7_zero <= 1'b0;
    end else begin
      s7_ctl  <= s6_ctl;
      s7_exp  <= st7_e;
      s7_frac <= st7_frac;
      s7_zero <= s6_zero;
    end
  end

  // Pack with overflow to inf and underflow to signed zero; a cleared pipe packs to +0.
  always_comb begin
    if (s7_ctl.special)                              st8_res = s7_ctl.spec;
    else if (s7_zero)                                st8_res = '0;
    else if (s7_exp >= $signed(10'(2 * EXP_BIAS + 1))) st8_res = {s7_ctl.sign, 8'hFF, 23'b0};
    else if (s7_exp <= 10'sd0)                       st8_res = {s7_ctl.sign, 31'b0};
    else                                             st8_res = {s7_ctl.sign, s7_exp[7:0], s7_frac};
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (!reset_n) result <= '0;
    else          result <= st8_res;
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed-vector bench for fp_add_sub: latency, streaming table, reset abort.
module tb_fp_add_sub;
  import fp_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        add_sub = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fp_add_sub dut (
    .clock   (clock),
    .reset_n (reset_n),
    .add_sub (add_sub),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result)
  );

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: result=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b);
    add_sub = op;
    dataa   = a;
    datab   = b;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[1]  = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000};
    vecs[2]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[4]  = '{1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001};
    vecs[5]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[6]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    vecs[7]  = '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000};
    vecs[8]  = '{1'b1, 32'h3F800000, 32'h40400000, 32'hC0000000};
    vecs[9]  = '{1'b1, 32'h3F800000, 32'h3F400000, 32'h3E800000};
    vecs[10] = '{1'b0, 32'h4B800001, 32'h3F800000, 32'h4B800002};
    vecs[11] = '{1'b0, 32'h4B800000, 32'h3F800000, 32'h4B800000};
    vecs[12] = '{1'b0, 32'h3F7FFFFF, 32'h33000000, 32'h3F800000};
    vecs[13] = '{1'b1, 32'h00800000, 32'h00800001, 32'h80000000};
    vecs[14] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000};
    vecs[15] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[16] = '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000};
    vecs[17] = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000};
    vecs[18] = '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000};
    vecs[19] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000};
    vecs[20] = '{1'b0, 32'h40400000, 32'hBF800000, 32'h40000000};
    vecs[21] = '{1'b0, 32'h3FC00000, 32'h40200000, 32'h40800000};
    vecs[22] = '{1'b0, 32'h00000000, 32'hBF800000, 32'hBF800000};
    vecs[23] = '{1'b1, 32'h40000000, 32'hC0000000, 32'h40800000};

    // Reset state.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_value", result, 32'h00000000);
    reset_n = 1'b1;

    // Single add: nothing for 7 cycles, answer on the 8th negedge after issue.
    drive(1'b0, 32'h3F800000, 32'h3F800000);
    for (int c = 1; c <= FP_LATENCY + 1; c++) begin
      @(negedge clock);
      drive(1'b0, 32'h0, 32'h0);
      if (c <= FP_LATENCY) check($sformatf("latency_early_%0d", c), result, 32'h00000000);
      else                 check("latency_add", result, 32'h40000000);
    end

    // Back-to-back stream of the whole table, mixed add_sub, one per clock.
    for (int c = 0; c < NV + FP_LATENCY + 1; c++) begin
      @(negedge clock);
      if (c >= FP_LATENCY + 1)
        check($sformatf("vec%0d", c - FP_LATENCY - 1), result, vecs[c - FP_LATENCY - 1].r);
      if (c < NV) drive(vecs[c].op, vecs[c].a, vecs[c].b);
      else        drive(1'b0, 32'h0, 32'h0);
    end

    // Reset mid-flight: three ops in the pipe, one-cycle reset, then a fresh op.
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h40400000, 32'h3F800000);
      @(negedge clock);
    end
    reset_n = 1'b0;
    drive(1'b1, 32'h40400000, 32'h40400000);
    @(negedge clock);
    reset_n = 1'b1;
    check("reset_abort", result, 32'h00000000);
    drive(1'b0, 32'h3FC00000, 32'h40200000);
    for (int c = 1; c <= FP_LATENCY + 1; c++) begin
      @(negedge clock);
      drive(1'b0, 32'h0, 32'h0);
      if (c <= FP_LATENCY) check($sformatf("post_reset_zero_%0d", c), result, 32'h00000000);
      else                 check("post_reset_op", result, 32'h40800000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
